multicycle_microprocessor: RTL

MULTICYCLE_MICROPROCESSOR -- requirements
Module: multicycle_microprocessor

---
 rtl/mp_pkg.sv | 42 ++++
 rtl/mp_regfile.sv | 32 +++
 rtl/multicycle_microprocessor.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mp_pkg.sv
// Shared opcodes, FSM states and seven-segment decode for the
// multicycle microprocessor.
package mp_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_BR  = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  // Active-low segments ordered {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mp_regfile.sv
// Four-entry register file: async reset, two combinational reads,
// one synchronous write port.
module mp_regfile #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        ra_i,
  input  logic [1:0]        rb_i,
  input  logic              we_i,
  input  logic [1:0]        wa_i,
  input  logic [DATA_W-1:0] wd_i,
  output logic [DATA_W-1:0] rda_o,
  output logic [DATA_W-1:0] rdb_o
);

  logic [DATA_W-1:0] r_q [4];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin
        r_q[i] <= '0;
      end
    end else if (we_i) begin
      r_q[wa_i] <= wd_i;
    end
  end

  assign rda_o = r_q[ra_i];
  assign rdb_o = r_q[rb_i];

endmodule

// File: rtl/multicycle_microprocessor.sv
// Multicycle 8-bit-instruction core: FETCH/EXEC/MEM/WB/HALT.
// Seven-segment output logic is built only with MP_HEX_DISPLAY_EN.
module multicycle_microprocessor
  import mp_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PC_W       = 8,
  parameter int DMEM_DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      instruction,
  input  logic            inst_valid,
  output logic            inst_ready,
  output logic [PC_W-1:0] pc,
  output logic [6:0]      lowerHex,
  output logic [6:0]      higherHex,
  output logic [1:0]      flags
);

  localparam int AW = $clog2(DMEM_DEPTH);

  state_t state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic              ovf_q, ovf_d;
  logic [1:0]        flags_q, flags_d;

  logic [DATA_W-1:0] mem_q [DMEM_DEPTH];
  logic              mem_we;
  logic [AW-1:0]     mem_idx;

  logic              rf_we;
  logic [1:0]        rf_wa;
  logic [DATA_W-1:0] rda, rdb;

  logic [1:0]        op, rs, rt, imm2;
  logic [DATA_W-1:0] simm, opx, opy, sum;
  logic [PC_W-1:0]   pc_inc, pc_br;
  logic              ovf, is_br, is_addi;
  logic              is_halt, is_jmp, is_alu;

  assign op   = ir_q[7:6];
  assign rs   = ir_q[5:4];
  assign rt   = ir_q[3:2];
  assign imm2 = ir_q[1:0];

  assign is_br   = (op == OP_BR) && (rs == 2'b00);
  assign is_addi = (op == OP_BR) && (rs != 2'b00);
  assign is_halt = is_br && (imm2 == 2'b11);
  assign is_jmp  = is_br && (imm2 != 2'b11);
  assign is_alu  = (op == OP_ADD) || is_addi;

  mp_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk_i (clk),
    .rst_i (reset),
    .ra_i  (rs),
    .rb_i  (rt),
    .we_i  (rf_we),
    .wa_i  (rf_wa),
    .wd_i  (alu_q),
    .rda_o (rda),
    .rdb_o (rdb)
  );

  // addi adds to R[rt]; add sums rs/rt; lw/sw form R[rs]+imm.
  assign simm = {{(DATA_W-2){imm2[1]}}, imm2};
  assign opx  = is_addi ? rdb : rda;
  assign opy  = (op == OP_ADD) ? rdb : simm;
  assign sum  = opx + opy;
  assign ovf  = (opx[DATA_W-1] == opy[DATA_W-1]) &&
                (sum[DATA_W-1] != opx[DATA_W-1]);

  assign pc_inc  = pc_q + PC_W'(1);
  assign pc_br   = pc_inc + {{(PC_W-2){imm2[1]}}, imm2};
  assign mem_idx = alu_q[AW-1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    alu_d   = alu_q;
    ovf_d   = ovf_q;
    flags_d = flags_q;
    rf_we   = 1'b0;
    rf_wa   = rt;
    mem_we  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (inst_valid) begin
          ir_d    = instruction;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_d = sum;
        ovf_d = ovf;
        unique case (1'b1)
          is_halt: begin
            flags_d[0] = 1'b1;
            state_d    = S_HALT;
          end
          is_jmp: begin
            pc_d    = pc_br;
            state_d = S_FETCH;
          end
          is_alu:  state_d = S_WB;
          default: state_d = S_MEM;
        endcase
      end
      S_MEM: begin
        if (op == OP_SW) begin
          mem_we  = 1'b1;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end else begin
          alu_d   = mem_q[mem_idx];
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we      = 1'b1;
        rf_wa      = (op == OP_ADD) ? imm2 : rt;
        flags_d[1] = flags_q[1] | (ovf_q & (op != OP_LW));
        pc_d       = pc_inc;
        state_d    = S_FETCH;
      end
      S_HALT: begin
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      alu_q   <= '0;
      ovf_q   <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      alu_q   <= alu_d;
      ovf_q   <= ovf_d;
      flags_q <= flags_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DMEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[mem_idx] <= rdb;
    end
  end

  assign inst_ready = (state_q == S_FETCH);
  assign pc         = pc_q;
  assign flags      = flags_q;

`ifdef MP_HEX_DISPLAY_EN
  logic [7:0] hex_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_q <= '0;
    end else if (state_q == S_WB) begin
      hex_q <= alu_q[7:0];
    end
  end

  assign lowerHex  = seg7(hex_q[3:0]);
  assign higherHex = seg7(hex_q[7:4]);
`else
  assign lowerHex  = 7'h7F;
  assign higherHex = 7'h7F;
`endif

endmodule
